// File: rtl/angle_sweep_gen.sv
// angle_sweep_gen: emits (radius, k*step mod FULL_TURN) pairs over a valid/ready handshake.
// Optional abort input when ANGLE_SWEEP_ABORT_EN is defined.
`default_nettype none

module angle_sweep_gen #(
  parameter int DATA_W    = 14,
  parameter int FULL_TURN = 1608,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef ANGLE_SWEEP_ABORT_EN
  input  logic              abort,
`endif
  input  logic [DATA_W-1:0] radius_in,
  input  logic [DATA_W-1:0] step_in,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] radius_out,
  output logic [DATA_W-1:0] angle_out,
  output logic [CNT_W-1:0]  index_out,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [DATA_W:0] TURN_X = (DATA_W+1)'(FULL_TURN);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] radius_q;
  logic [DATA_W-1:0] step_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] angle_q;
  logic [CNT_W-1:0]  index_q;
  logic              valid_q;
  logic              last_q;
  logic              done_q;
  logic              err_q;

  logic [DATA_W:0]   angle_sum;
  logic [DATA_W-1:0] angle_d;
  logic [CNT_W-1:0]  index_d;
  logic [CNT_W-1:0]  last_idx;
  logic              accept;
  logic              abort_req;

  // Step is checked < FULL_TURN at start, so one subtraction keeps angle in range.
  assign angle_sum = {1'b0, angle_q} + {1'b0, step_q};
  assign angle_d   = (angle_sum >= TURN_X) ? DATA_W'(angle_sum - TURN_X)
                                           : angle_sum[DATA_W-1:0];
  assign index_d   = index_q + CNT_W'(1);
  assign last_idx  = count_q - CNT_W'(1);
  assign accept    = valid_q && out_ready;

`ifdef ANGLE_SWEEP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      radius_q <= '0;
      step_q   <= '0;
      count_q  <= '0;
      angle_q  <= '0;
      index_q  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if ({1'b0, step_in} >= TURN_X) begin
              err_q <= 1'b1;
            end else if (count_in == '0) begin
              done_q <= 1'b1;
            end else begin
              radius_q <= radius_in;
              step_q   <= step_in;
              count_q  <= count_in;
              angle_q  <= '0;
              index_q  <= '0;
              valid_q  <= 1'b1;
              last_q   <= (count_in == CNT_W'(1));
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          // Abort wins over a same-cycle accept; the pending beat is dropped.
          if (abort_req || (accept && index_q == last_idx)) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (accept) begin
            index_q <= index_d;
            angle_q <= angle_d;
            last_q  <= (index_d == last_idx);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = valid_q;
  assign radius_out = radius_q;
  assign angle_out  = angle_q;
  assign index_out  = index_q;
  assign last       = last_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_angle_sweep_gen.sv
// tb_angle_sweep_gen: directed self-checking bench for angle_sweep_gen.
`default_nettype none

module tb_angle_sweep_gen;
  localparam int DATA_W    = 14;
  localparam int FULL_TURN = 1608;
  localparam int CNT_W     = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [DATA_W-1:0] radius_in = '0;
  logic [DATA_W-1:0] step_in = '0;
  logic [CNT_W-1:0]  count_in = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] radius_out;
  logic [DATA_W-1:0] angle_out;
  logic [CNT_W-1:0]  index_out;
  logic              last;
  logic              busy;
  logic              done;
  logic              err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  angle_sweep_gen #(.DATA_W(DATA_W), .FULL_TURN(FULL_TURN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef ANGLE_SWEEP_ABORT_EN
    .abort      (abort),
`endif
    .radius_in  (radius_in),
    .step_in    (step_in),
    .count_in   (count_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .radius_out (radius_out),
    .angle_out  (angle_out),
    .index_out  (index_out),
    .last       (last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep with out_ready high; optionally pokes start with other operands mid-run.
  task automatic sweep(input int r, input int st, input int n, input bit poke);
    start = 1'b1; radius_in = DATA_W'(r); step_in = DATA_W'(st); count_in = CNT_W'(n);
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("s%0d_valid_k%0d", st, k), 32'(out_valid), 1);
      chk($sformatf("s%0d_busy_k%0d", st, k), 32'(busy), 1);
      chk($sformatf("s%0d_angle_k%0d", st, k), 32'(angle_out), 32'((k * st) % FULL_TURN));
      chk($sformatf("s%0d_index_k%0d", st, k), 32'(index_out), 32'(k));
      chk($sformatf("s%0d_last_k%0d", st, k), 32'(last), 32'(k == n - 1));
      chk($sformatf("s%0d_radius_k%0d", st, k), 32'(radius_out), 32'(r));
      chk($sformatf("s%0d_done_k%0d", st, k), 32'(done), 0);
      if (poke && k == 1) begin
        start = 1'b1; radius_in = 5; step_in = 7; count_in = 2;
      end
      tick();
      start = 1'b0;
    end
    chk($sformatf("s%0d_done_end", st), 32'(done), 1);
    chk($sformatf("s%0d_valid_end", st), 32'(out_valid), 0);
    chk($sformatf("s%0d_busy_end", st), 32'(busy), 0);
    chk($sformatf("s%0d_last_end", st), 32'(last), 0);
    tick();
    chk($sformatf("s%0d_done_pulse", st), 32'(done), 0);
    chk($sformatf("s%0d_idle_valid", st), 32'(out_valid), 0);
  endtask

  initial begin
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int bk;

    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_outs", {out_valid, radius_out, angle_out, index_out, last, busy, done, err}, 0);
    rst_n = 1'b1;
    tick();

    sweep(1920, 402, 4, 1'b0);
    sweep(1920, 700, 4, 1'b0);
    sweep(300, 1607, 3, 1'b0);
    sweep(77, 0, 1, 1'b0);
    sweep(1920, 402, 4, 1'b1);

    // Backpressure: ready pattern 1,0,0,1,0,1 accepts exactly three beats
    start = 1'b1; radius_in = 1234; step_in = 100; count_in = 3; out_ready = 1'b0;
    tick();
    start = 1'b0;
    bk = 0;
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i];
      chk($sformatf("bp_valid_c%0d", i), 32'(out_valid), 1);
      chk($sformatf("bp_angle_c%0d", i), 32'(angle_out), 32'(bk * 100));
      chk($sformatf("bp_index_c%0d", i), 32'(index_out), 32'(bk));
      chk($sformatf("bp_last_c%0d", i), 32'(last), 32'(bk == 2));
      chk($sformatf("bp_radius_c%0d", i), 32'(radius_out), 1234);
      tick();
      if (pat[i]) bk++;
    end
    out_ready = 1'b1;
    chk("bp_done", 32'(done), 1);
    chk("bp_valid_end", 32'(out_valid), 0);
    tick();

    // Count zero: immediate done, never valid
    start = 1'b1; step_in = 10; count_in = 0;
    tick();
    start = 1'b0;
    chk("cnt0_done", 32'(done), 1);
    chk("cnt0_valid", 32'(out_valid), 0);
    chk("cnt0_busy", 32'(busy), 0);
    tick();
    chk("cnt0_done_pulse", 32'(done), 0);
    chk("cnt0_valid2", 32'(out_valid), 0);

    // Step equal to FULL_TURN is rejected
    start = 1'b1; step_in = DATA_W'(FULL_TURN); count_in = 4;
    tick();
    start = 1'b0;
    chk("badstep_err", 32'(err), 1);
    chk("badstep_busy", 32'(busy), 0);
    chk("badstep_valid", 32'(out_valid), 0);
    chk("badstep_done", 32'(done), 0);
    tick();
    chk("badstep_err_pulse", 32'(err), 0);
    chk("badstep_valid2", 32'(out_valid), 0);

    // Reset after three beats of a ten-point sweep
    start = 1'b1; radius_in = 1000; step_in = 402; count_in = 10; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("rst_mid_index_before", 32'(index_out), 3);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_outs", {out_valid, radius_out, angle_out, index_out, last, busy, done, err}, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_mid_no_done", 32'(done), 0);
    chk("rst_mid_idle", 32'(out_valid), 0);
    sweep(1000, 402, 2, 1'b0);

`ifdef ANGLE_SWEEP_ABORT_EN
    start = 1'b1; radius_in = 500; step_in = 50; count_in = 8; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ab_index_k1", 32'(index_out), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", 32'(out_valid), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 1);
    chk("ab_index_held", 32'(index_out), 1);
    chk("ab_angle_held", 32'(angle_out), 50);
    tick();
    chk("ab_done_pulse", 32'(done), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_idle_done", 32'(done), 0);
    chk("ab_idle_valid", 32'(out_valid), 0);
    sweep(500, 50, 2, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
